// File: rtl/bgr_ctrl_pkg.sv
// Shared types and sizing helpers for the bandgap start-up sequencer.
package bgr_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      KICK   = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      READY  = 3'd4,
      FAULT  = 3'd5
   } bgr_state_t;

   localparam int unsigned RETRY_W = 4;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/bgr_startup_ctrl.sv
// Bandgap start-up sequencer: kicks the core with porst, qualifies vbg_ok,
// retries on loss of regulation and latches a fault once retries run out.
//
//   state  | meaning
//   IDLE   | waiting for en, all outputs low
//   KICK   | porst high, PULSE_CYCLES long
//   SETTLE | porst low, core settling for SETTLE_CYCLES
//   CHECK  | waiting for OK_FILTER consecutive ok_s highs, bounded by TIMEOUT_CYCLES
//   READY  | bgr_ready high, watching for OK_FILTER consecutive ok_s lows
//   FAULT  | retry budget spent, fault high until en drops
module bgr_startup_ctrl
   import bgr_ctrl_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES   = 4,
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned OK_FILTER      = 3,
   parameter int unsigned TIMEOUT_CYCLES = 32,
   parameter int unsigned MAX_RETRIES    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               vbg_ok,
   output logic               porst,
   output logic               bgr_ready,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_cnt
);

   localparam int unsigned PHASE_MAX = max3(PULSE_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
   localparam int unsigned PH_W      = $clog2(PHASE_MAX + 1);
   localparam int unsigned FLT_W     = $clog2(OK_FILTER + 1);

   // Phase counter runs down to zero; loading N-1 gives an N-cycle phase.
   localparam logic [PH_W-1:0]    PULSE_LD   = PH_W'(PULSE_CYCLES - 1);
   localparam logic [PH_W-1:0]    SETTLE_LD  = PH_W'(SETTLE_CYCLES - 1);
   localparam logic [PH_W-1:0]    TIMEOUT_LD = PH_W'(TIMEOUT_CYCLES - 1);
   localparam logic [FLT_W-1:0]   FLT_TC     = FLT_W'(OK_FILTER);
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

   bgr_state_t       state;
   bgr_state_t       nxt_state;
   logic [PH_W-1:0]  ph_cnt;
   logic [FLT_W-1:0] flt_cnt;
   logic [FLT_W-1:0] flt_inc;
   logic             ok_s;
   logic             accept;
   logic             reject;
   logic             timeout;
   logic             retry_ok;
   logic             retry_take;

   sync_2ff u_sync_ok (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (vbg_ok),
      .q     (ok_s)
   );

   always_comb begin
      flt_inc    = (flt_cnt == FLT_TC) ? flt_cnt : flt_cnt + 1'b1;
      accept     = (state == CHECK) && ok_s && (flt_inc == FLT_TC);
      reject     = (state == READY) && !ok_s && (flt_inc == FLT_TC);
      timeout    = (state == CHECK) && (ph_cnt == '0);
      retry_ok   = (retry_cnt < RETRY_MAX);
      retry_take = 1'b0;
      nxt_state  = state;
      case (state)
         IDLE:    if (en) nxt_state = KICK;
         KICK:    if (ph_cnt == '0) nxt_state = SETTLE;
         SETTLE:  if (ph_cnt == '0) nxt_state = CHECK;
         CHECK: begin
            // Accept outranks a timeout landing on the same cycle.
            if (accept) begin
               nxt_state = READY;
            end else if (timeout) begin
               nxt_state  = retry_ok ? KICK : FAULT;
               retry_take = retry_ok;
            end
         end
         READY: begin
            if (reject) begin
               nxt_state  = retry_ok ? KICK : FAULT;
               retry_take = retry_ok;
            end
         end
         FAULT:   nxt_state = FAULT;
         default: nxt_state = IDLE;
      endcase
      if (!en) begin
         nxt_state  = IDLE;
         retry_take = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ph_cnt    <= '0;
         flt_cnt   <= '0;
         retry_cnt <= '0;
         porst     <= 1'b0;
         bgr_ready <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= nxt_state;
         porst     <= (nxt_state == KICK);
         bgr_ready <= (nxt_state == READY);
         fault     <= (nxt_state == FAULT);

         if (!en)             retry_cnt <= '0;
         else if (retry_take) retry_cnt <= retry_cnt + 1'b1;

         if (nxt_state != state) begin
            case (nxt_state)
               KICK:    ph_cnt <= PULSE_LD;
               SETTLE:  ph_cnt <= SETTLE_LD;
               CHECK:   ph_cnt <= TIMEOUT_LD;
               default: ph_cnt <= '0;
            endcase
         end else if (ph_cnt != '0) begin
            ph_cnt <= ph_cnt - 1'b1;
         end

         // Filter tracks a run of highs in CHECK and a run of lows in READY.
         if (nxt_state != state)                  flt_cnt <= '0;
         else if (state == CHECK)                 flt_cnt <= ok_s ? flt_inc : '0;
         else if (state == READY)                 flt_cnt <= ok_s ? '0 : flt_inc;
         else                                     flt_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// Directed bench for bgr_startup_ctrl with default parameters; cycle c is the
// c-th clock edge after en is driven high, outputs are sampled 1 ns after it.
module tb_bgr_startup_ctrl;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       vbg_ok;
   logic       porst;
   logic       bgr_ready;
   logic       fault;
   logic [3:0] retry_cnt;

   int n_run  = 0;
   int n_fail = 0;

   bgr_startup_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .vbg_ok    (vbg_ok),
      .porst     (porst),
      .bgr_ready (bgr_ready),
      .fault     (fault),
      .retry_cnt (retry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ep, input logic er,
                          input logic ef, input logic [3:0] ec);
      chk({tag, ".porst"},     {3'b000, porst},     {3'b000, ep});
      chk({tag, ".bgr_ready"}, {3'b000, bgr_ready}, {3'b000, er});
      chk({tag, ".fault"},     {3'b000, fault},     {3'b000, ef});
      chk({tag, ".retry_cnt"}, retry_cnt,           ec);
   endtask

   initial begin
      int   npulse;
      logic prev_porst;

      rst_n  = 1'b0;
      en     = 1'b0;
      vbg_ok = 1'b0;
      #12;
      chk_all("reset", 1'b0, 1'b0, 1'b0, 4'd0);
      rst_n = 1'b1;
      tick(1);
      chk_all("post_reset_idle", 1'b0, 1'b0, 1'b0, 4'd0);

      // Nominal start, then a 2-cycle drop (ignored) and a 3-cycle drop (retry).
      vbg_ok = 1'b1;
      tick(4);
      en = 1'b1;
      for (int c = 1; c <= 70; c++) begin
         tick(1);
         chk_all($sformatf("nominal_c%0d", c),
                 (c >= 1 && c <= 4) || (c >= 45 && c <= 48),
                 (c >= 24 && c <= 44) || (c >= 68),
                 1'b0,
                 (c >= 45) ? 4'd1 : 4'd0);
         vbg_ok = !(c == 30 || c == 31 || c == 40 || c == 41 || c == 42);
      end
      en = 1'b0;
      tick(1);
      chk_all("abort_ready", 1'b0, 1'b0, 1'b0, 4'd0);

      // Glitchy qualification: ok_s seen as 1,1,0,1,1,1 on cycles 22..27.
      vbg_ok = 1'b0;
      tick(4);
      en = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         tick(1);
         chk_all($sformatf("glitch_c%0d", c), (c >= 1 && c <= 4), (c >= 27), 1'b0, 4'd0);
         vbg_ok = (c == 19 || c == 20 || c >= 22);
      end
      en = 1'b0;
      tick(1);
      chk_all("glitch_abort", 1'b0, 1'b0, 1'b0, 4'd0);

      // Never OK: three 52-cycle attempts, fault from cycle 157.
      vbg_ok = 1'b0;
      tick(4);
      en         = 1'b1;
      npulse     = 0;
      prev_porst = 1'b0;
      for (int c = 1; c <= 170; c++) begin
         tick(1);
         chk_all($sformatf("never_ok_c%0d", c),
                 (c >= 1 && c <= 4) || (c >= 53 && c <= 56) || (c >= 105 && c <= 108),
                 1'b0,
                 (c >= 157),
                 (c >= 105) ? 4'd2 : ((c >= 53) ? 4'd1 : 4'd0));
         if (porst && !prev_porst) npulse++;
         prev_porst = porst;
      end
      chk("never_ok.pulse_count", 4'(npulse), 4'd3);
      en = 1'b0;
      tick(1);
      chk_all("fault_clear", 1'b0, 1'b0, 1'b0, 4'd0);

      // Abort during SETTLE (cycle 10), re-enable at cycle 12.
      tick(2);
      en = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick(1);
         chk_all($sformatf("abort_settle_c%0d", c),
                 (c >= 1 && c <= 4) || (c >= 13 && c <= 16), 1'b0, 1'b0, 4'd0);
         if (c == 10) en = 1'b0;
         if (c == 12) en = 1'b1;
      end
      en = 1'b0;
      tick(2);

      // Abort on the second KICK cycle, re-enable at cycle 4.
      en = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick(1);
         chk_all($sformatf("abort_kick_c%0d", c),
                 (c >= 1 && c <= 2) || (c >= 5 && c <= 8), 1'b0, 1'b0, 4'd0);
         if (c == 2) en = 1'b0;
         if (c == 4) en = 1'b1;
      end
      en = 1'b0;
      tick(2);

      // Asynchronous reset mid-KICK, between edges.
      en = 1'b1;
      tick(2);
      chk_all("areset_pre", 1'b1, 1'b0, 1'b0, 4'd0);
      #3;
      rst_n = 1'b0;
      #1;
      chk_all("areset_low", 1'b0, 1'b0, 1'b0, 4'd0);
      #2;
      rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick(1);
         chk_all($sformatf("areset_restart_c%0d", c), (c <= 4), 1'b0, 1'b0, 4'd0);
      end
      en = 1'b0;
      tick(1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
